roll_button_conditioner: RTL and testbench

Converts the raw active-low roll pushbutton into the single-cycle `roll` strobe the dice-game FSM consumes. It synchronizes the pad signal, debounces it with a 4-state machine, and emits exactly one clean pulse per accepted press. It also provides the debounced level, a release pulse and a wrapping roll counter for the debug LEDs. It sits between the board pin and the FSM `roll` input in the dice-game top level.

---
 rtl/dice_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/roll_button_conditioner.sv | 118 +++++++++++
 tb/tb_roll_button_conditioner.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dice_pkg.sv
// Shared types and default constants for the dice-game button path.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DEBOUNCE_DEFAULT      = 500000;
    localparam int DEBOUNCE_CNT_W        = 20;
    localparam int REPEAT_DELAY_DEFAULT  = 25000000;
    localparam int REPEAT_PERIOD_DEFAULT = 12500000;
    localparam int ROLL_CNT_W            = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous pad inputs.
// Both flops load RESET_VAL under reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/roll_button_conditioner.sv
// Active-low roll button to single-cycle roll strobe with debounce.
// Optional hold-to-repeat built in when ROLL_AUTOREPEAT_EN is defined.
module roll_button_conditioner
    import dice_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = DEBOUNCE_CNT_W,
    parameter int REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
    parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  btn_n,
    output logic                  roll_pulse,
    output logic                  held,
    output logic                  release_pulse,
    output logic [ROLL_CNT_W-1:0] roll_count
);

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clock(clock),
        .reset(reset),
        .d    (btn_n),
        .q    (s)
    );

`ifdef ROLL_AUTOREPEAT_EN
    // Reload to DELAY-PERIOD so later pulses reuse the same terminal compare.
    localparam logic [31:0] RepLast   = 32'(REPEAT_DELAY - 1);
    localparam logic [31:0] RepReload = 32'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [31:0] rep_cnt;
`else
    // Repeat timing has no effect unless auto-repeat is built in.
    if (REPEAT_DELAY < REPEAT_PERIOD) begin : g_repeat_cfg
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            roll_pulse    <= 1'b0;
            release_pulse <= 1'b0;
            held          <= 1'b0;
            roll_count    <= '0;
`ifdef ROLL_AUTOREPEAT_EN
            rep_cnt       <= '0;
`endif
        end else begin
            roll_pulse    <= 1'b0;
            release_pulse <= 1'b0;
`ifdef ROLL_AUTOREPEAT_EN
            rep_cnt       <= '0;
`endif
            unique case (state)
                IDLE: begin
                    if (!s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CntLast) begin
                        state      <= PRESSED;
                        held       <= 1'b1;
                        roll_pulse <= 1'b1;
                        roll_count <= roll_count + ROLL_CNT_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PRESSED: begin
                    if (s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
`ifdef ROLL_AUTOREPEAT_EN
                    else if (rep_cnt == RepLast) begin
                        rep_cnt    <= RepReload;
                        roll_pulse <= 1'b1;
                        roll_count <= roll_count + ROLL_CNT_W'(1);
                    end else begin
                        rep_cnt <= rep_cnt + 32'd1;
                    end
`endif
                end
                RELEASE_WAIT: begin
                    if (!s) begin
                        state <= PRESSED;
                    end else if (cnt == CntLast) begin
                        state         <= IDLE;
                        held          <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_roll_button_conditioner.sv
// Bench for roll_button_conditioner: vector table, directed corners,
// and random presses against a run-length reference model.
module tb_roll_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       btn_n = 1'b1;
    logic       roll_pulse;
    logic       held;
    logic       release_pulse;
    logic [7:0] roll_count;

    always #5 clock = ~clock;

    roll_button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .btn_n        (btn_n),
        .roll_pulse   (roll_pulse),
        .held         (held),
        .release_pulse(release_pulse),
        .roll_count   (roll_count)
    );

    int checks = 0;
    int fails  = 0;

    // Reference: two-sample delay, then a level flips after D+1
    // consecutive samples that disagree with the accepted level.
    logic       q1 = 1'b1, q2 = 1'b1;
    logic       mheld = 1'b0, mroll = 1'b0, mrel = 1'b0;
    logic [7:0] mcnt = 8'd0;
    int         run = 0;
    int         rep = 0;

    typedef struct {
        logic       btn;
        logic       rst;
        logic       roll;
        logic       hld;
        logic       rel;
        logic [7:0] cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step(input logic b, input logic r);
        logic s;
        logic pl;
        if (r) begin
            q1 = 1'b1; q2 = 1'b1;
            mheld = 1'b0; mroll = 1'b0; mrel = 1'b0;
            mcnt = 8'd0; run = 0; rep = 0;
        end else begin
            s = q2; q2 = q1; q1 = b;
            mroll = 1'b0; mrel = 1'b0;
            pl = ~s;
            if (pl != mheld) begin
                run++;
                rep = 0;
                if (run == D + 1) begin
                    mheld = pl;
                    run = 0;
                    if (pl) begin
                        mroll = 1'b1;
                        mcnt++;
                    end else begin
                        mrel = 1'b1;
                    end
                end
            end else begin
`ifdef ROLL_AUTOREPEAT_EN
                if (mheld && run == 0) begin
                    rep++;
                    if (rep >= RD && (rep - RD) % RP == 0) begin
                        mroll = 1'b1;
                        mcnt++;
                    end
                end else begin
                    rep = 0;
                end
`endif
                run = 0;
            end
        end
    endtask

    task automatic tick(input logic b, input logic r);
        btn_n = b;
        reset = r;
        @(posedge clock);
        model_step(b, r);
        @(negedge clock);
        chk("model_roll", 32'(roll_pulse), 32'(mroll));
        chk("model_held", 32'(held), 32'(mheld));
        chk("model_release", 32'(release_pulse), 32'(mrel));
        chk("model_count", 32'(roll_count), 32'(mcnt));
    endtask

    task automatic push(input logic b, input logic r, input logic ro,
                        input logic h, input logic re, input logic [7:0] c);
        vec_t v;
        v.btn = b; v.rst = r; v.roll = ro;
        v.hld = h; v.rel = re; v.cnt = c;
        tbl.push_back(v);
    endtask

    initial begin
        int npulse, first, nrel, relidx, act, exp_n, idx[$];

        push(1, 1, 0, 0, 0, 0);
        push(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) push(0, 0, 0, 0, 0, 0);
        push(0, 0, 1, 1, 0, 1);
        push(0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 6; i++) push(1, 0, 0, 1, 0, 1);
        push(1, 0, 0, 0, 1, 1);
        push(1, 0, 0, 0, 0, 1);

        @(negedge clock);
        foreach (tbl[i]) begin
            tick(tbl[i].btn, tbl[i].rst);
            chk($sformatf("tbl%0d_roll", i), 32'(roll_pulse), 32'(tbl[i].roll));
            chk($sformatf("tbl%0d_held", i), 32'(held), 32'(tbl[i].hld));
            chk($sformatf("tbl%0d_rel", i), 32'(release_pulse), 32'(tbl[i].rel));
            chk($sformatf("tbl%0d_cnt", i), 32'(roll_count), 32'(tbl[i].cnt));
        end

        // Clean press held for 30 cycles.
        npulse = 0; first = -1;
        for (int i = 0; i < 30; i++) begin
            tick(0, 0);
            if (roll_pulse) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
`ifdef ROLL_AUTOREPEAT_EN
        exp_n = 2;
`else
        exp_n = 1;
`endif
        chk("press_pulses", 32'(npulse), 32'(exp_n));
        chk("press_latency", 32'(first), 32'd6);
        chk("press_held", 32'(held), 32'd1);
        chk("press_count", 32'(roll_count), 32'(1 + exp_n));
        for (int i = 0; i < 10; i++) tick(1, 0);
        chk("press_released", 32'(held), 32'd0);

        // Input bouncing every 2 cycles must never be accepted.
        act = 0;
        for (int i = 0; i < 30; i++) begin
            tick((i < 20) ? logic'((i / 2) % 2) : 1'b1, 0);
            if (roll_pulse || release_pulse || held) act++;
        end
        chk("bounce_activity", 32'(act), 32'd0);
        chk("bounce_count", 32'(roll_count), 32'(1 + exp_n));

        // Bounce during release: one release only, timed from last rise.
        for (int i = 0; i < 10; i++) tick(0, 0);
        chk("relb_pressed", 32'(held), 32'd1);
        npulse = 0; nrel = 0; relidx = -1;
        for (int i = 0; i < 16; i++) begin
            tick((i < 2 || i >= 4) ? 1'b1 : 1'b0, 0);
            if (roll_pulse) npulse++;
            if (release_pulse) begin
                nrel++;
                relidx = i - 4;
            end
        end
        chk("relb_no_roll", 32'(npulse), 32'd0);
        chk("relb_one_release", 32'(nrel), 32'd1);
        chk("relb_latency", 32'(relidx), 32'd6);

        // Reset two cycles into the press wait discards the press.
        npulse = 0;
        for (int i = 0; i < 4; i++) begin
            tick(0, 0);
            if (roll_pulse) npulse++;
        end
        tick(0, 1);
        chk("rst_no_pulse", 32'(npulse), 32'd0);
        chk("rst_count", 32'(roll_count), 32'd0);
        chk("rst_held", 32'(held), 32'd0);
        first = -1;
        for (int i = 0; i < 10; i++) begin
            tick(0, 0);
            if (roll_pulse && first < 0) first = i;
        end
        chk("rst_repress_latency", 32'(first), 32'd6);
        chk("rst_repress_count", 32'(roll_count), 32'd1);
        for (int i = 0; i < 10; i++) tick(1, 0);

        // 256 clean presses wrap the roll counter back to zero.
        tick(1, 1);
        npulse = 0;
        for (int p = 0; p < 256; p++) begin
            for (int i = 0; i < 14; i++) begin
                tick((i < 6) ? 1'b0 : 1'b1, 0);
                if (roll_pulse) npulse++;
            end
        end
        chk("wrap_pulses", 32'(npulse), 32'd256);
        chk("wrap_count", 32'(roll_count), 32'd0);

`ifdef ROLL_AUTOREPEAT_EN
        tick(1, 1);
        for (int i = 0; i < 48; i++) begin
            tick((i < 36) ? 1'b0 : 1'b1, 0);
            if (roll_pulse) idx.push_back(i);
        end
        chk("rep_pulses", 32'(idx.size()), 32'd3);
        if (idx.size() == 3) begin
            chk("rep_first", 32'(idx[0]), 32'd6);
            chk("rep_second", 32'(idx[1]), 32'd26);
            chk("rep_third", 32'(idx[2]), 32'd34);
        end
        chk("rep_count", 32'(roll_count), 32'd3);
`endif

        // Random level segments, occasionally with reset.
        for (int seg = 0; seg < 400; seg++) begin
            logic lvl;
            int   len;
            lvl = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            if ($urandom_range(0, 39) == 0) tick(lvl, 1);
            for (int i = 0; i < len; i++) tick(lvl, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
